// File: rtl/e_muldiv_unit.sv
// e_muldiv_unit: iterative signed/unsigned mul/div, one bit per cycle.
// Results land in HI/LO; MTHI/MTLO write them directly.
module e_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_con_start,
   input  logic [2:0]       i_con_op,
   input  logic [WIDTH-1:0] i_data_A,
   input  logic [WIDTH-1:0] i_data_B,
   output logic             o_con_busy,
   output logic             o_con_done,
   output logic             o_con_divzero,
   output logic [WIDTH-1:0] o_data_hi,
   output logic [WIDTH-1:0] o_data_lo
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               sgn1_q, sgn1_d;
   logic               sgn2_q, sgn2_d;
   logic               isdiv_q, isdiv_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   logic               sgn_op;
   logic               accept;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     sum, trial;
   logic [2*WIDTH-1:0] prod_n;
   logic [WIDTH-1:0]   quo_n, rem_n;

   assign sgn_op = (i_con_op == 3'd0) || (i_con_op == 3'd2);
   assign accept = i_con_start && (state_q == S_IDLE) && (i_con_op <= 3'd5);
   assign a_abs  = (sgn_op && i_data_A[WIDTH-1]) ? (~i_data_A + 1'b1) : i_data_A;
   assign b_abs  = (sgn_op && i_data_B[WIDTH-1]) ? (~i_data_B + 1'b1) : i_data_B;

   // acc holds {partial, multiplier} for MUL and {remainder, dividend} for DIV
   assign sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
   assign trial  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
   assign prod_n = sgn1_q ? (~acc_q + 1'b1) : acc_q;
   assign quo_n  = sgn1_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
   assign rem_n  = sgn2_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                          : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      sgn1_d  = sgn1_q;
      sgn2_d  = sgn2_q;
      isdiv_d = isdiv_q;
      done_d  = 1'b0;
      dz_d    = dz_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               dz_d = 1'b0;
               case (i_con_op)
                  3'd0, 3'd1: begin
                     acc_d   = {{WIDTH{1'b0}}, a_abs};
                     opb_d   = b_abs;
                     sgn1_d  = sgn_op & (i_data_A[WIDTH-1] ^ i_data_B[WIDTH-1]);
                     sgn2_d  = 1'b0;
                     isdiv_d = 1'b0;
                     cnt_d   = CW'(WIDTH);
                     state_d = S_MUL;
                  end
                  3'd2, 3'd3: begin
                     acc_d   = {{WIDTH{1'b0}}, a_abs};
                     opa_d   = i_data_A;
                     opb_d   = b_abs;
                     sgn1_d  = sgn_op & (i_data_A[WIDTH-1] ^ i_data_B[WIDTH-1]);
                     sgn2_d  = sgn_op & i_data_A[WIDTH-1];
                     isdiv_d = 1'b1;
                     cnt_d   = CW'(WIDTH);
                     state_d = S_DIV;
                  end
                  3'd4: begin
                     hi_d   = i_data_A;
                     done_d = 1'b1;
                  end
                  3'd5: begin
                     lo_d   = i_data_A;
                     done_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            if (acc_q[0]) acc_d = {sum, acc_q[WIDTH-1:1]};
            else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         S_DIV: begin
            if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else               acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (!isdiv_q) begin
               {hi_d, lo_d} = prod_n;
            end else if (opb_q == '0) begin
               hi_d = opa_q;
               lo_d = '1;
               dz_d = 1'b1;
            end else begin
               hi_d = rem_n;
               lo_d = quo_n;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         sgn1_q  <= 1'b0;
         sgn2_q  <= 1'b0;
         isdiv_q <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sgn1_q  <= sgn1_d;
         sgn2_q  <= sgn2_d;
         isdiv_q <= isdiv_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign o_con_busy    = (state_q != S_IDLE);
   assign o_con_done    = done_q;
   assign o_con_divzero = dz_q;
   assign o_data_hi     = hi_q;
   assign o_data_lo     = lo_q;
endmodule
